corevx_mem_responder: RTL
=========================

// Module: corevx_mem_responder
// PURPOSE
//  Parametrised Avalon-MM memory responder: word-addressed RAM with bursts, wait states, read latency and a decode-error window.
//  Serves the cache's m_* master port in benches and the FPGA bring-up top; its behaviour is deterministic and cycle-exact.
//  An address alias bit (bypass bit) maps onto the same storage, so bypassed and cached paths see identical data.
// PARAMETERS
//  ADDR_WIDTH   34       byte address width of m_address
//  DATA_WIDTH   32       data width; power of two, >= 8
//  DEPTH_WORDS  131072   storage depth in DATA_WIDTH words; power of two
//  BURST_WIDTH  5        width of m_burstcount (max burst 2**BURST_WIDTH-1)
//  WAIT_STATES  0        extra waitrequest cycles before command accept (total stall = 1+WAIT_STATES)
//  READ_LATENCY 1        cycles from accept to first m_readdatavalid, >= 1
//  BYPASS_BIT   31       address bit ignored for decode (alias bit)
//  ERR_BASE     0        first word index of the error window
//  ERR_SIZE     0        words in the error window (0 = no window)
// PORTS
//  clk             in   1            clock
//  rst_n           in   1            asynchronous active-low reset
//  m_address       in   ADDR_WIDTH   byte address; sampled on accept of the first beat
//  m_burstcount    in   BURST_WIDTH  beats; 0 treated as 1
//  m_read          in   1            read command
//  m_write         in   1            write command / write beat
//  m_writedata     in   DATA_WIDTH   write beat data
//  m_byteenable    in   DATA_WIDTH/8 byte lanes to write
//  m_waitrequest   out  1            1 = command/beat not accepted this cycle
//  m_readdata      out  DATA_WIDTH   read beat data
//  m_readdatavalid out  1            read beat valid
//  m_response      out  2            00 OKAY, 11 DECODEERROR; valid with readdatavalid, or on write beat accept
//  stat_reads      out  32           accepted read commands (wraps)
//  stat_writes     out  32           accepted write beats (wraps)
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, m_waitrequest=1, m_readdatavalid=0, m_readdata=0, m_response=2'b11, stats=0.
//   Storage is not cleared. Reset mid-burst aborts it; remaining beats are neither returned nor written.
//  Decode: word = (m_address & ~(1<<BYPASS_BIT)) >> log2(DATA_WIDTH/8). Error if word >= DEPTH_WORDS or in
//   [ERR_BASE, ERR_BASE+ERR_SIZE). Error beat: response 11, write suppressed, readdata 0. Otherwise response 00.
//  Burst beats use word+i; error is re-evaluated per beat.
//  FSM: IDLE -> STALL on (m_read|m_write); STALL counts WAIT_STATES cycles, then ACCEPT.
//   ACCEPT: m_waitrequest=0 for one cycle; command, address and burstcount are captured here.
//    Read: stat_reads++, -> RLAT. Write: beat 0 written, stat_writes++; -> WBURST if burstcount>1, else IDLE.
//    If command dropped before ACCEPT: return to IDLE, no side effect.
//   RLAT: READ_LATENCY-1 cycles, then RBURST. RBURST: one beat per cycle, m_readdatavalid=1 on consecutive cycles; -> IDLE after last beat.
//   WBURST: m_waitrequest = !m_write; each m_write cycle accepts one beat; -> IDLE after last beat.
//   m_waitrequest=1 in IDLE, STALL, RLAT and RBURST.
//  m_read and m_write both high at IDLE: read wins, write ignored.
//  Write response is combinational from the current beat decode in its accept cycle; read response is registered with its beat.
//  Outside valid cycles m_response=2'b11 and m_readdata holds its last value.
//  Read-after-write to the same word returns the new data; there is no hazard window.
// CONFIGURATION
//  COREVX_MEM_RESPONDER_RANDSTALL_EN defined:
//   - a 16-bit GLFSR (seed 16'hACE1, advances every cycle) adds stalls.
//   - in STALL and WBURST, LFSR bit0=1 forces m_waitrequest=1 for that cycle.
//   - RBURST beats may gap: m_readdatavalid is deasserted while LFSR bit1=1.
//  Undefined: timing is exactly as above and no LFSR is instantiated.
// STRUCTURE
//  corevx_defs: add localparams MEM_RESP_OKAY=2'b00, MEM_RESP_DECODEERR=2'b11, and the FSM state enum.
//  Sub-module corevx_lfsr (WIDTH=16, SEED): instantiated only under COREVX_MEM_RESPONDER_RANDSTALL_EN.
// TESTING
//  1. Read 0x0, mem[0]=32'hBEAFDEAD, WAIT_STATES=0, READ_LATENCY=1 -> waitrequest low on cycle 2;
//     readdatavalid on the next cycle with data BEAFDEAD, response 00.
//  2. Write 0x80000000, data FFCC2211, be=4'hF -> response 00 on accept; read 0x0 returns FFCC2211 (alias).
//  3. Write burst of 4 at 0x40 with be=4'b0011 on beat 2 -> only low half of word 0x12 updated;
//     read burst of 4 returns 4 consecutive readdatavalid beats.
//  4. ERR_BASE=8, ERR_SIZE=1, read burst of 3 at 0x1C -> responses 00,11,00 with beat 1 data 0;
//     write to 0x20 leaves storage unchanged.
//  5. Address 0x1_0000_0000 (above depth) -> response 11; burstcount=0 -> exactly one beat.
//  6. rst_n asserted in beat 2 of a 4-beat read -> readdatavalid=0 immediately; next read served normally, stat_reads=1.

Source files
------------

// File: rtl/corevx_mem_responder_pkg.sv
// Shared definitions for the corevx memory responder: response codes and FSM state encoding.
package corevx_mem_responder_pkg;

  localparam logic [1:0] MEM_RESP_OKAY      = 2'b00;
  localparam logic [1:0] MEM_RESP_DECODEERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STALL,
    ST_ACCEPT,
    ST_RLAT,
    ST_RBURST,
    ST_WBURST
  } mem_state_e;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (maximal length)
  localparam logic [15:0] LFSR16_TAPS = 16'hB400;

endpackage

// File: rtl/corevx_mem_responder_if.sv
// Avalon-MM bus bundle between a cache m_* master port and the memory responder.
interface corevx_mem_responder_if #(
  parameter int ADDR_WIDTH  = 34,
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0]   m_address;
  logic [BURST_WIDTH-1:0]  m_burstcount;
  logic                    m_read;
  logic                    m_write;
  logic [DATA_WIDTH-1:0]   m_writedata;
  logic [DATA_WIDTH/8-1:0] m_byteenable;
  logic                    m_waitrequest;
  logic [DATA_WIDTH-1:0]   m_readdata;
  logic                    m_readdatavalid;
  logic [1:0]              m_response;

  modport master (
    output m_address, m_burstcount, m_read, m_write, m_writedata, m_byteenable,
    input  m_waitrequest, m_readdata, m_readdatavalid, m_response
  );

  modport slave (
    input  m_address, m_burstcount, m_read, m_write, m_writedata, m_byteenable,
    output m_waitrequest, m_readdata, m_readdatavalid, m_response
  );
endinterface

// File: rtl/corevx_lfsr.sv
// Free-running Galois LFSR; used only by the responder's random-stall build option.
module corevx_lfsr
  import corevx_mem_responder_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1),
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR16_TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (q[0]) begin
      q <= (q >> 1) ^ TAPS;
    end else begin
      q <= q >> 1;
    end
  end

endmodule

// File: rtl/corevx_mem_responder.sv
// Avalon-MM word-addressed RAM responder: bursts, wait states, read latency, decode-error window.
// Build option COREVX_MEM_RESPONDER_RANDSTALL_EN adds LFSR-driven stalls and read-beat gaps.
module corevx_mem_responder
  import corevx_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH   = 34,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 131072,
  parameter int BURST_WIDTH  = 5,
  parameter int WAIT_STATES  = 0,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS_BIT   = 31,
  parameter int ERR_BASE     = 0,
  parameter int ERR_SIZE     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  corevx_mem_responder_if.slave bus,
  output logic [31:0]           stat_reads,
  output logic [31:0]           stat_writes
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int WW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  mem_state_e            state;
  logic [15:0]           cnt;
  logic [WW-1:0]         base_word;
  logic [BURST_WIDTH-1:0] nbeats;
  logic [BURST_WIDTH-1:0] beat;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;

  function automatic logic [WW-1:0] addr_to_word(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] m;
    m             = a;
    m[BYPASS_BIT] = 1'b0;
    return WW'(m >> OFS);
  endfunction

  function automatic logic word_err(input logic [WW-1:0] w);
    return (w >= WW'(DEPTH_WORDS)) ||
           ((w >= WW'(ERR_BASE)) && (w < WW'(ERR_BASE + ERR_SIZE)));
  endfunction

  function automatic logic [BURST_WIDTH-1:0] burst_norm(input logic [BURST_WIDTH-1:0] bc);
    return (bc == '0) ? BURST_WIDTH'(1) : bc;
  endfunction

`ifdef COREVX_MEM_RESPONDER_RANDSTALL_EN
  logic [15:0] lfsr_q;
  logic        rnd_stall;
  logic        rnd_gap;

  corevx_lfsr #(.WIDTH(16), .SEED(16'hACE1)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  assign rnd_stall = lfsr_q[0];
  assign rnd_gap   = lfsr_q[1];
`else
  logic rnd_stall;
  logic rnd_gap;
  assign rnd_stall = 1'b0;
  assign rnd_gap   = 1'b0;
`endif

  // In ACCEPT the beat address comes straight off the bus; afterwards from the captured base.
  logic [WW-1:0]         cur_word;
  logic                  cur_err;
  logic [IDX_W-1:0]      cur_idx;
  logic [BURST_WIDTH-1:0] cmd_beats;
  logic                  wr_accept;
  logic                  rd_issue;

  assign cur_word  = (state == ST_ACCEPT) ? addr_to_word(bus.m_address) : base_word + WW'(beat);
  assign cur_err   = word_err(cur_word);
  assign cur_idx   = cur_word[IDX_W-1:0];
  assign cmd_beats = burst_norm(bus.m_burstcount);

  assign wr_accept = ((state == ST_ACCEPT) && bus.m_write && !bus.m_read) ||
                     ((state == ST_WBURST) && bus.m_write && !rnd_stall);

  assign rd_issue  = ((state == ST_ACCEPT) && bus.m_read && (READ_LATENCY == 1)) ||
                     ((state == ST_RLAT) && (cnt == 16'(READ_LATENCY - 2))) ||
                     ((state == ST_RBURST) && !rnd_gap);

  always_comb begin
    case (state)
      ST_ACCEPT: bus.m_waitrequest = 1'b0;
      ST_WBURST: bus.m_waitrequest = !bus.m_write || rnd_stall;
      default:   bus.m_waitrequest = 1'b1;
    endcase
  end

  // Write response is live in the accept cycle; otherwise the registered read beat drives it.
  assign bus.m_response      = wr_accept ? (cur_err ? MEM_RESP_DECODEERR : MEM_RESP_OKAY)
                             : (rvalid ? rresp : MEM_RESP_DECODEERR);
  assign bus.m_readdata      = rdata;
  assign bus.m_readdatavalid = rvalid;

  always_ff @(posedge clk) begin
    if (wr_accept && !cur_err) begin
      for (int i = 0; i < BYTES; i++) begin
        if (bus.m_byteenable[i]) mem[cur_idx][8*i +: 8] <= bus.m_writedata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      base_word   <= '0;
      nbeats      <= '0;
      beat        <= '0;
      rvalid      <= 1'b0;
      rdata       <= '0;
      rresp       <= MEM_RESP_DECODEERR;
      stat_reads  <= '0;
      stat_writes <= '0;
    end else begin
      rvalid <= rd_issue;
      if (rd_issue) begin
        rdata <= cur_err ? '0 : mem[cur_idx];
        rresp <= cur_err ? MEM_RESP_DECODEERR : MEM_RESP_OKAY;
      end
      if (wr_accept) stat_writes <= stat_writes + 32'd1;

      case (state)
        ST_IDLE: begin
          if (bus.m_read || bus.m_write) begin
            state <= ST_STALL;
            cnt   <= '0;
          end
        end
        ST_STALL: begin
          if (!(bus.m_read || bus.m_write)) begin
            state <= ST_IDLE;
          end else if (!rnd_stall) begin
            if (cnt == 16'(WAIT_STATES)) state <= ST_ACCEPT;
            else                         cnt   <= cnt + 16'd1;
          end
        end
        ST_ACCEPT: begin
          base_word <= addr_to_word(bus.m_address);
          nbeats    <= cmd_beats;
          cnt       <= '0;
          if (bus.m_read) begin
            stat_reads <= stat_reads + 32'd1;
            if (READ_LATENCY == 1) begin
              beat  <= BURST_WIDTH'(1);
              state <= (cmd_beats == BURST_WIDTH'(1)) ? ST_IDLE : ST_RBURST;
            end else begin
              beat  <= '0;
              state <= ST_RLAT;
            end
          end else if (bus.m_write) begin
            beat  <= BURST_WIDTH'(1);
            state <= (cmd_beats == BURST_WIDTH'(1)) ? ST_IDLE : ST_WBURST;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RLAT: begin
          if (cnt == 16'(READ_LATENCY - 2)) begin
            beat  <= BURST_WIDTH'(1);
            state <= (nbeats == BURST_WIDTH'(1)) ? ST_IDLE : ST_RBURST;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_RBURST: begin
          if (!rnd_gap) begin
            beat <= beat + BURST_WIDTH'(1);
            if (beat == nbeats - BURST_WIDTH'(1)) state <= ST_IDLE;
          end
        end
        ST_WBURST: begin
          if (wr_accept) begin
            beat <= beat + BURST_WIDTH'(1);
            if (beat == nbeats - BURST_WIDTH'(1)) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
